psum_binarizer: RTL

- Directly downstream of the PE array.
- Takes the O_CH per-output-channel partial sums the array produces on each input-channel pass and accumulates them over a configurable number of passes.
- After the last pass, compares each channel's total against a per-channel threshold (batch-norm folded) and emits one sign bit per channel.
- Its output is the binarized activation vector for the next layer.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/threshold_bank.sv | 32 +++
 rtl/psum_binarizer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared defaults and state type for the binarized-network datapath blocks.
package bnn_pkg;

  localparam int DEF_WIDTH     = 14;
  localparam int DEF_O_CH      = 64;
  localparam int DEF_ACC_WIDTH = DEF_WIDTH + 4;
  localparam int DEF_PASS_W    = 5;

  // Largest number of input-channel passes folded into one output group.
  localparam int MAX_PASS = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/threshold_bank.sv
// Per-channel signed threshold register file: one write port, all entries
// visible at once on a flat read bus (channel 0 in the MSBs).
module threshold_bank #(
  parameter int O_CH      = 64,
  parameter int ACC_WIDTH = 18
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      wr_en_in,
  input  logic [$clog2(O_CH)-1:0]   wr_addr_in,
  input  logic [ACC_WIDTH-1:0]      wr_data_in,
  output logic [O_CH*ACC_WIDTH-1:0] thr_flat_out
);

  localparam int AW = $clog2(O_CH);

  for (genvar k = 0; k < O_CH; k++) begin : g_entry
    logic [ACC_WIDTH-1:0] entry_q;

    // Entry k captures the write data when addressed.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        entry_q <= '0;
      end else if (wr_en_in && (wr_addr_in == AW'(k))) begin
        entry_q <= wr_data_in;
      end
    end

    assign thr_flat_out[ACC_WIDTH*(O_CH-k)-1 -: ACC_WIDTH] = entry_q;
  end

endmodule

// File: rtl/psum_binarizer.sv
// Accumulates per-channel PE-array partial sums over a configurable number of
// passes, then compares each total against its threshold and emits sign bits.
module psum_binarizer
  import bnn_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int O_CH      = DEF_O_CH,
  parameter int ACC_WIDTH = WIDTH + 4,
  parameter int PASS_W    = DEF_PASS_W
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    psum_valid_in,
  input  logic [O_CH*WIDTH-1:0]   psum_in,
  input  logic [PASS_W-1:0]       pass_num_in,
  input  logic                    thr_wr_en_in,
  input  logic [$clog2(O_CH)-1:0] thr_addr_in,
  input  logic [ACC_WIDTH-1:0]    thr_data_in,
  output logic                    sign_valid_out,
  output logic [O_CH-1:0]         sign_out,
  output logic                    busy_out
);

  localparam int CNT_W = $clog2(MAX_PASS) + 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]         eff_q, eff_d, eff_in;
  logic                     acc_en, last_pass;
  logic                     sign_valid_q;
  logic [O_CH*ACC_WIDTH-1:0] thr_flat;

  threshold_bank #(
    .O_CH      (O_CH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_thr (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_en_in     (thr_wr_en_in),
    .wr_addr_in   (thr_addr_in),
    .wr_data_in   (thr_data_in),
    .thr_flat_out (thr_flat)
  );

  // Clamp the requested pass count into 1..MAX_PASS.
  always_comb begin
    if (pass_num_in == '0) begin
      eff_in = CNT_W'(1);
    end else if (int'(pass_num_in) > MAX_PASS) begin
      eff_in = CNT_W'(MAX_PASS);
    end else begin
      eff_in = CNT_W'(pass_num_in);
    end
  end

  // Control state, pass counter, latched pass count and output pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      pass_cnt_q   <= '0;
      eff_q        <= '0;
      sign_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_cnt_q   <= pass_cnt_d;
      eff_q        <= eff_d;
      sign_valid_q <= last_pass;
    end
  end

  // Next-state logic: decide whether this valid is a group's final pass.
  always_comb begin
    state_d    = state_q;
    pass_cnt_d = pass_cnt_q;
    eff_d      = eff_q;
    acc_en     = 1'b0;
    last_pass  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psum_valid_in) begin
          acc_en = 1'b1;
          eff_d  = eff_in;
          if (eff_in == CNT_W'(1)) begin
            last_pass = 1'b1;
          end else begin
            pass_cnt_d = CNT_W'(1);
            state_d    = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (psum_valid_in) begin
          acc_en = 1'b1;
          if (pass_cnt_q == eff_q - CNT_W'(1)) begin
            last_pass  = 1'b1;
            pass_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulators are zero whenever the FSM is IDLE, so the first pass of a
  // group (and a single-pass group) shares the same acc + psum adder.
  for (genvar k = 0; k < O_CH; k++) begin : g_lane
    logic        [WIDTH-1:0]     lane;
    logic signed [ACC_WIDTH-1:0] psum_ext, sum, thr, acc_q, acc_d;
    logic                        sign_bit_q;

    assign lane     = psum_in[WIDTH*(O_CH-k)-1 -: WIDTH];
    assign psum_ext = {{(ACC_WIDTH-WIDTH){lane[WIDTH-1]}}, lane};
    assign sum      = acc_q + psum_ext;
    assign thr      = thr_flat[ACC_WIDTH*(O_CH-k)-1 -: ACC_WIDTH];
    assign acc_d    = last_pass ? '0 : sum;

    // Lane accumulator and registered sign decision.
    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        acc_q      <= '0;
        sign_bit_q <= 1'b0;
      end else if (acc_en) begin
        acc_q <= acc_d;
        if (last_pass) begin
          sign_bit_q <= (sum >= thr);
        end
      end
    end

    assign sign_out[O_CH-1-k] = sign_bit_q;
  end

  assign sign_valid_out = sign_valid_q;
  assign busy_out       = (state_q == ACCUM);

endmodule
